// File: rtl/uart_rx_axis.sv
// uart_rx_axis: oversampling 8N1-style UART receiver with a valid/ready
// byte output. The start edge is glitch-filtered, and each bit is decided
// by a 2-of-3 majority vote around the bit centre. A single holding register
// feeds the downstream consumer. Framing errors and overruns are reported
// as one-cycle pulses.
//
// Parameter constraints: OVERSAMPLE must be even and >= 8, and the derived
// prescaler DIV must be >= 1.
module uart_rx_axis #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  // Prescaler value rounded to the nearest integer.
  localparam int DIV = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

  // The vote window is centred on the middle sample of a bit.
  localparam int M  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] VOTE_A      = SW'(M - 1);
  localparam logic [SW-1:0] VOTE_B      = SW'(M);
  localparam logic [SW-1:0] VOTE_C      = SW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [PW-1:0]        r_presc;
  logic [SW-1:0]        r_sample_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_votes;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_rx;
  logic                 w_tick;
  logic                 w_wrap;
  logic                 w_vote_tick;
  logic                 w_vote;
  logic                 w_start_edge;
  logic                 w_deliver;
  logic                 w_stop_bad;
  logic                 w_handshake;
  logic [DATA_BITS-1:0] w_shift_next;

  // Every decision uses the synchronised line, never the raw pin.
  assign w_rx = r_sync2;

  // One tick per prescaler period; one wrap per bit period.
  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_wrap      = w_tick && (r_sample_cnt == SAMPLE_LAST);
  assign w_vote_tick = w_tick && (r_sample_cnt == VOTE_C);

  // 2-of-3 majority vote. The third sample is the live value at the vote tick.
  assign w_vote = (r_votes[0] & r_votes[1]) |
                  (r_votes[0] & w_rx)       |
                  (r_votes[1] & w_rx);

  // A low line seen in IDLE is the candidate start edge.
  assign w_start_edge = (r_state == S_IDLE) && !w_rx;

  // Stop-bit outcomes. Both are evaluated only at the stop vote.
  assign w_deliver  = (r_state == S_STOP) && w_vote_tick && w_vote;
  assign w_stop_bad = (r_state == S_STOP) && w_vote_tick && !w_vote;

  assign w_handshake = r_valid && i_out_ready;

  // The next value of the LSB-first shift register. The voted bit enters at
  // the MSB and everything else moves one place toward the LSB.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
    if (gi == DATA_BITS - 1) begin : g_msb
      assign w_shift_next[gi] = w_vote;
    end else begin : g_lower
      assign w_shift_next[gi] = r_shift[gi + 1];
    end
  end

  // Two-flop synchroniser for the asynchronous line. It resets to the idle level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else if (clk_en) begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Oversampling prescaler. It restarts at the start edge so that sample
  // phases line up with the detected edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (clk_en) begin
      if (w_start_edge || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Receive FSM: frame tracking, vote sampling and data shifting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_WAIT_IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_votes      <= '0;
    end else if (clk_en) begin
      // The sample counter free-runs on ticks. A state change below
      // overrides this and clears it.
      if (w_tick) begin
        r_sample_cnt <= w_wrap ? '0 : (r_sample_cnt + SW'(1));
        if (r_sample_cnt == VOTE_A) begin
          r_votes[0] <= w_rx;
        end
        if (r_sample_cnt == VOTE_B) begin
          r_votes[1] <= w_rx;
        end
      end

      unique case (r_state)
        // Leave only when the line is at its idle level. Otherwise a
        // break or mid-frame reset would look like a start bit.
        S_WAIT_IDLE: begin
          if (w_rx) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
          end
        end

        S_IDLE: begin
          if (!w_rx) begin
            r_state      <= S_START;
            r_sample_cnt <= '0;
          end
        end

        // A start bit that votes high at its centre was a glitch.
        S_START: begin
          if (w_vote_tick && w_vote) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
          end else if (w_wrap) begin
            r_state      <= S_DATA;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
          end
        end

        S_DATA: begin
          if (w_vote_tick) begin
            r_shift <= w_shift_next;
          end
          if (w_wrap) begin
            r_sample_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end

        // Return to IDLE at the stop-bit centre rather than its end. This
        // gives the next start edge half a bit of slack.
        S_STOP: begin
          if (w_vote_tick) begin
            r_state      <= w_vote ? S_IDLE : S_WAIT_IDLE;
            r_sample_cnt <= '0;
          end
        end

        default: begin
          r_state      <= S_WAIT_IDLE;
          r_sample_cnt <= '0;
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake and error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (clk_en) begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || w_handshake) begin
          // A load in the same cycle as a handshake keeps valid high.
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          // The consumer is stalled. Keep the old byte and drop the new one.
          r_overrun <= 1'b1;
        end
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed frames driven into uart_rx_axis at 16 clk/bit
// (DIV=1, OVERSAMPLE=16).
// - The bench keeps an expected-byte queue and counts of pending error pulses.
// - A negedge monitor checks handshakes, pulses, data hold and clk_en freezing.
// - Each test adds hand-computed literal checks.
module tb_uart_rx_axis;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_out_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;

  uart_rx_axis #(
    .CLK_FREQ_HZ (16000000),
    .BAUD        (1000000),
    .OVERSAMPLE  (16),
    .DATA_BITS   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation state.
  logic [7:0] exp_q[$];
  int         pend_ferr = 0;
  int         pend_ovr = 0;
  bit         wild = 1'b0;  // bytes in this window come from an undefined frame
  bit         toggle_en = 1'b0;

  // Observations gathered by the monitor.
  int         rise_cnt = 0;
  int         valid_cyc_cnt = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  int         start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
    start_cyc = cyc;
    i_rx = 1'b0;
    step(cpb);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      step(cpb);
    end
    i_rx = stop_bit;
    step(cpb);
    i_rx = 1'b1;
  endtask

  // clk_en driver: steady high, or toggling every cycle.
  initial begin : en_drv
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) clk_en = ~clk_en;
      else           clk_en = 1'b1;
    end
  end

  // Monitor. Signals at a negedge show the state produced by the previous
  // edge (p_* inputs) and the inputs the next edge will sample.
  initial begin : monitor
    logic       p_rst, p_en, p_valid, p_rdy, p_ferr, p_ovr;
    logic [7:0] p_data;
    p_rst = 1'b0; p_en = 1'b1; p_valid = 1'b0; p_rdy = 1'b0;
    p_ferr = 1'b0; p_ovr = 1'b0; p_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        check("reset_outputs", {21'd0, o_valid, o_frame_err, o_overrun, o_data}, 32'd0);
      end else if (!p_en) begin
        check("frozen_outputs", {21'd0, o_valid, o_frame_err, o_overrun, o_data},
              {21'd0, p_valid, p_ferr, p_ovr, p_data});
      end else begin
        if (p_valid && !p_rdy) begin
          check("stall_keeps_valid", o_valid, 1);
          check("stall_keeps_data", o_data, p_data);
        end
        if (o_frame_err) begin
          ferr_cnt++;
          $display("frame error pulse at cycle %0d", cyc);
          check("frame_err_was_expected", pend_ferr > 0, 1);
          if (pend_ferr > 0) pend_ferr--;
        end
        if (o_overrun) begin
          ovr_cnt++;
          $display("overrun pulse at cycle %0d", cyc);
          check("overrun_was_expected", pend_ovr > 0, 1);
          if (pend_ovr > 0) pend_ovr--;
        end
        if (o_valid && !p_valid) begin
          rise_cnt++;
          rise_cyc  = cyc;
          rise_data = o_data;
          $display("rx byte %02h valid at cycle %0d", o_data, cyc);
        end
      end
      if (o_valid) valid_cyc_cnt++;
      // Handshake will happen at the coming edge.
      if (rst && clk_en && o_valid && i_out_ready && !wild) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h required none", o_data);
        end else begin
          check("rx_byte", o_data, exp_q.pop_front());
        end
      end
      p_rst = rst; p_en = clk_en; p_valid = o_valid; p_rdy = i_out_ready;
      p_ferr = o_frame_err; p_ovr = o_overrun; p_data = o_data;
    end
  end

  initial begin : stim
    int r0, v0, f0, o0, lat;

    // Reset
    step(4);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_frame_err", o_frame_err, 0);
    check("rst_o_overrun", o_overrun, 0);
    rst = 1'b1;
    step(20);

    // T1: plain byte, consumer ready
    i_out_ready = 1'b1;
    r0 = rise_cnt; v0 = valid_cyc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h6E);
    send_frame(8'h6E, 1'b1, 16);
    step(20);
    lat = rise_cyc - start_cyc;
    $display("t1 latency %0d clk", lat);
    check("t1_rise_count", rise_cnt - r0, 1);
    check("t1_valid_one_cycle", valid_cyc_cnt - v0, 1);
    check("t1_data", rise_data, 8'h6E);
    check("t1_latency_window", (lat >= 152) && (lat <= 158), 1);
    check("t1_no_errors", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // T2: 4-clk glitch is rejected, then a real byte
    r0 = rise_cnt; f0 = ferr_cnt;
    i_rx = 1'b0;
    step(4);
    i_rx = 1'b1;
    step(30);
    check("t2_glitch_no_valid", rise_cnt - r0, 0);
    check("t2_glitch_no_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h6F);
    send_frame(8'h6F, 1'b1, 16);
    step(20);
    check("t2_rise_count", rise_cnt - r0, 1);
    check("t2_data", rise_data, 8'h6F);

    // T3: bad stop bit, idle, good frame
    r0 = rise_cnt; f0 = ferr_cnt;
    pend_ferr = 1;
    send_frame(8'h55, 1'b0, 16);
    step(32);
    exp_q.push_back(8'h70);
    send_frame(8'h70, 1'b1, 16);
    step(20);
    check("t3_ferr_pulses", ferr_cnt - f0, 1);
    check("t3_rise_count", rise_cnt - r0, 1);
    check("t3_data", rise_data, 8'h70);
    check("t3_ferr_consumed", pend_ferr, 0);

    // T4: stalled consumer, second byte overruns
    i_out_ready = 1'b0;
    r0 = rise_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h6E);
    pend_ovr = 1;
    send_frame(8'h6E, 1'b1, 16);
    send_frame(8'h6F, 1'b1, 16);
    step(20);
    check("t4_valid_held", o_valid, 1);
    check("t4_data_held", o_data, 8'h6E);
    check("t4_overrun_pulses", ovr_cnt - o0, 1);
    check("t4_rise_count", rise_cnt - r0, 1);
    i_out_ready = 1'b1;
    step(1);
    i_out_ready = 1'b0;
    step(5);
    check("t4_valid_dropped", o_valid, 0);
    check("t4_data_kept", o_data, 8'h6E);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_no_new_valid", rise_cnt - r0, 1);

    // T5: reset in bit 3 of 0x41 while line low
    i_out_ready = 1'b1;
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    start_cyc = cyc;
    i_rx = 1'b0; step(16);  // start
    i_rx = 1'b1; step(16);  // b0
    i_rx = 1'b0; step(16);  // b1
    step(16);               // b2
    step(2);                // into b3
    rst = 1'b0;
    step(4);
    rst = 1'b1;
    wild = 1'b1;
    step(42);               // rest of b3, b4, b5
    i_rx = 1'b1; step(16);  // b6
    i_rx = 1'b0; step(16);  // b7
    i_rx = 1'b1; step(16);  // stop
    check("t5_no_valid_while_busy", rise_cnt - r0, 0);
    step(120);
    wild = 1'b0;
    check("t5_no_ferr", ferr_cnt - f0, 0);
    check("t5_no_overrun", ovr_cnt - o0, 0);
    exp_q.push_back(8'h62);
    send_frame(8'h62, 1'b1, 16);
    step(20);
    check("t5_data", rise_data, 8'h62);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_valid_low", o_valid, 0);

    // T6: clk_en toggling, 500000 baud (32 clk/bit)
    r0 = rise_cnt; f0 = ferr_cnt;
    toggle_en = 1'b1;
    exp_q.push_back(8'h64);
    send_frame(8'h64, 1'b1, 32);
    step(60);
    toggle_en = 1'b0;
    step(4);
    check("t6_rise_count", rise_cnt - r0, 1);
    check("t6_data", rise_data, 8'h64);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_no_ferr", ferr_cnt - f0, 0);

    check("end_pending_ferr", pend_ferr, 0);
    check("end_pending_ovr", pend_ovr, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
- 8N1-style UART receiver that converts the serial RX pin into a byte-wide valid/ready stream.
- Sits directly upstream of the BIOS command parser and feeds its i_data/i_valid/o_in_ready input.
- Uses an oversampling baud tick, glitch-rejecting start detection, 3-sample majority voting and a one-entry output holding register.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, samples per bit; must be even and >= 8.
- DATA_BITS, 8, data bits per frame, LSB first.
- DIV, round(CLK_FREQ_HZ/(BAUD*OVERSAMPLE)), derived prescaler value; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- clk_en  in  1  global advance enable; every register holds when 0.
- i_rx  in  1  asynchronous serial line; idle level is 1.
- o_data  out  DATA_BITS  received byte.
- o_valid  out  1  o_data is valid.
- i_out_ready  in  1  consumer accepts o_data.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- o_overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full.

Behaviour:
- One clock. Reset is synchronous and active-low on rst.
  - While rst=0: state=WAIT_IDLE, prescaler=0, sample_cnt=0, bit_cnt=0, shift=0, both synchronizer flops=1, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0.
  - rst takes effect regardless of clk_en.
- Everything else advances only on cycles with clk_en=1, including the output handshake.
- Synchronizer: i_rx passes through 2 flops to give rx_s. All decisions use rx_s.
- Prescaler: counts 0..DIV-1 and produces tick when it equals DIV-1. It is forced to 0 on entry to START so samples are aligned to the detected edge.
- sample_cnt: 0..OVERSAMPLE-1, increments on tick and wraps. It reaches wrap once per bit period. It is cleared on every state change.
- Majority: with M=OVERSAMPLE/2, rx_s is captured on ticks where sample_cnt = M-1, M and M+1. The vote is evaluated at the M+1 tick as 2-of-3.
- State WAIT_IDLE: leave for IDLE when rx_s=1. This prevents a false start after reset mid-frame or after a break.
- State IDLE: rx_s=0 -> START.
- State START: at the vote, result 1 (glitch) -> IDLE. Result 0 -> continue; at the sample_cnt wrap -> DATA with bit_cnt=0.
- State DATA:
  - At each vote, shift the voted bit into shift, LSB first (shift <= {bit, shift[DATA_BITS-1:1]}).
  - At the wrap: if bit_cnt=DATA_BITS-1 -> STOP, else bit_cnt+1.
- State STOP: at the vote:
  - Result 1 -> deliver shift to the output stage, then IDLE immediately. Mid-stop resync is allowed.
  - Result 0 -> o_frame_err=1 for one cycle, byte discarded, -> WAIT_IDLE.
- Output stage, evaluated in the same cycle as a deliver:
  - handshake = o_valid & i_out_ready.
  - Deliver with (!o_valid or handshake): o_data<=shift, o_valid<=1. Back-to-back handshake plus load keeps o_valid=1.
  - Deliver with o_valid & !i_out_ready: old o_data retained, new byte dropped, o_overrun=1 for one cycle.
  - No deliver and handshake: o_valid<=0. o_data holds its last value.
- o_data must not change while o_valid=1 and i_out_ready=0.
- Latency: o_valid rises 1 cycle after the stop-bit vote. With DIV=1 and OVERSAMPLE=16 this is between 9*16+8 and 9*16+14 clk after the falling edge of i_rx for the start bit (synchronizer plus edge alignment).
- clk_en=0 freezes all counters and outputs. Effective sample rate is clk_en-qualified ticks.
- Error pulses never coincide with an o_valid rise for the same frame.

Test Plan:
- Common bench setup: CLK_FREQ_HZ=16000000, BAUD=1000000, OVERSAMPLE=16 (DIV=1, 16 clk/bit); clk_en=1 unless stated.
1. Send 0x6E with i_out_ready=1 -> o_valid high exactly 1 cycle, o_data=0x6E, within 152..158 clk of the start edge; no error pulses.
2. Drive i_rx low for 4 clk, then high -> no o_valid and no error pulse; a following 0x6F is received correctly.
3. Send 0x55 with stop bit 0, then line idle 32 clk, then 0x70 -> single o_frame_err pulse and no o_valid for 0x55; o_data=0x70 for the second frame.
4. Hold i_out_ready=0 and send 0x6E then 0x6F -> o_valid=1 with o_data=0x6E throughout; o_overrun pulses once at the second stop vote. Then raise i_out_ready for 1 cycle -> o_valid falls, no data delivered.
5. Assert rst=0 during bit 3 of a 0x41 frame while the line holds low data, release with line still low -> no output until the line idles high. Next frame 0x62 is received correctly and no error flags are raised.
6. Toggle clk_en 1/0 every cycle and send 0x64 at 500000 baud -> o_data=0x64 received correctly; all outputs are frozen on clk_en=0 cycles.
